// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the LEGv8 memory-access stage:
// datapath widths, handshake FSM encoding and pipeline-register layouts.
package mem_stage_pkg;

    localparam int WORD  = 64;
    localparam int REG_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [WORD-1:0]  alu_result;
        logic [WORD-1:0]  read_data2;
        logic [WORD-1:0]  branch_target;
        logic             zero;
        logic [REG_W-1:0] write_register;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             uncond_branch;
    } ex_mem_t;

    typedef struct packed {
        logic             valid;
        logic [WORD-1:0]  read_data;
        logic [WORD-1:0]  alu_result;
        logic [REG_W-1:0] write_register;
        logic             reg_write;
        logic             mem_to_reg;
    } mem_wb_t;

    function automatic logic needs_access(input logic valid, input logic mem_read,
                                          input logic mem_write);
        return valid & (mem_read | mem_write);
    endfunction

    // A store wins over a load when both control bits are set.
    function automatic logic is_load(input logic valid, input logic mem_read,
                                     input logic mem_write);
        return valid & mem_read & ~mem_write;
    endfunction

    function automatic logic take_branch(input logic valid, input logic branch,
                                         input logic uncond_branch, input logic zero);
        return valid & (uncond_branch | (branch & zero));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [WORD-1:0] dmem_addr;
    logic [WORD-1:0] dmem_wdata;
    logic [WORD-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// IDLE/ACCESS handshake FSM: tracks the outstanding data-memory access and
// produces the request, the upstream stall and the stage-completion strobe.
module dmem_handshake
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic done
);

    state_t state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, so it lives inside the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= ACCESS;
                ACCESS:  if (ack)   state <= start ? ACCESS : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ack in IDLE is a stray and has no effect on any of these.
    assign req   = (state == ACCESS);
    assign stall = (state == ACCESS) & ~ack;
    assign done  = ~stall;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: EX/MEM register, branch resolution, data-memory
// access via the req/ack bus, and the MEM/WB register feeding write-back.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic             valid_in,
    input  logic [WORD-1:0]  alu_result_in,
    input  logic [WORD-1:0]  read_data2_in,
    input  logic [WORD-1:0]  branch_target_in,
    input  logic             zero_in,
    input  logic [REG_W-1:0] write_register_in,
    input  logic             reg_write_in,
    input  logic             mem_to_reg_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             branch_in,
    input  logic             uncond_branch_in,

    mem_stage_if.master      bus,

    output logic             stall,
    output logic             pc_src,
    output logic [WORD-1:0]  branch_target_out,
    output logic             valid_out,
    output logic [WORD-1:0]  read_data_out,
    output logic [WORD-1:0]  alu_result_out,
    output logic [REG_W-1:0] write_register_out,
    output logic             reg_write_out,
    output logic             mem_to_reg_out
);

    ex_mem_t ex_next;
    ex_mem_t ex_q;
    mem_wb_t wb_q;
    logic    start;
    logic    done;
    logic    req;

    // NOTE: every field is assigned unconditionally, so no latch can form.
    always_comb begin
        ex_next = '{
            valid:          valid_in,
            alu_result:     alu_result_in,
            read_data2:     read_data2_in,
            branch_target:  branch_target_in,
            zero:           zero_in,
            write_register: write_register_in,
            reg_write:      reg_write_in,
            mem_to_reg:     mem_to_reg_in,
            mem_read:       mem_read_in,
            mem_write:      mem_write_in,
            branch:         branch_in,
            uncond_branch:  uncond_branch_in
        };
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= ex_next;
        end
    end

    // A new access starts only on an edge where EX/MEM actually captures.
    assign start = ~stall & needs_access(valid_in, mem_read_in, mem_write_in);

    dmem_handshake u_handshake (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ack   (bus.dmem_ack),
        .req   (req),
        .stall (stall),
        .done  (done)
    );

    // EX/MEM is frozen while req is high, so the bus fields stay stable.
    assign bus.dmem_req   = req;
    assign bus.dmem_we    = ex_q.mem_write;
    assign bus.dmem_addr  = ex_q.alu_result;
    assign bus.dmem_wdata = ex_q.read_data2;

    assign pc_src            = take_branch(ex_q.valid, ex_q.branch, ex_q.uncond_branch, ex_q.zero);
    assign branch_target_out = ex_q.branch_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else if (done) begin
            wb_q.valid          <= ex_q.valid;
            wb_q.reg_write      <= ex_q.valid & ex_q.reg_write;
            wb_q.mem_to_reg     <= ex_q.mem_to_reg;
            wb_q.write_register <= ex_q.write_register;
            wb_q.alu_result     <= ex_q.alu_result;
            wb_q.read_data      <= is_load(ex_q.valid, ex_q.mem_read, ex_q.mem_write)
                                   ? bus.dmem_rdata : '0;
        end else begin
            // Waiting on memory: emit a bubble, keep the data fields.
            wb_q.valid     <= 1'b0;
            wb_q.reg_write <= 1'b0;
        end
    end

    assign valid_out          = wb_q.valid;
    assign read_data_out      = wb_q.read_data;
    assign alu_result_out     = wb_q.alu_result;
    assign write_register_out = wb_q.write_register;
    assign reg_write_out      = wb_q.reg_write;
    assign mem_to_reg_out     = wb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, zero-wait load, wait-state store,
// back-to-back loads, branch decisions, bubbles, stray ack, reset mid-access.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [WORD-1:0]  alu_result_in;
    logic [WORD-1:0]  read_data2_in;
    logic [WORD-1:0]  branch_target_in;
    logic             zero_in;
    logic [REG_W-1:0] write_register_in;
    logic             reg_write_in;
    logic             mem_to_reg_in;
    logic             mem_read_in;
    logic             mem_write_in;
    logic             branch_in;
    logic             uncond_branch_in;
    logic             stall;
    logic             pc_src;
    logic [WORD-1:0]  branch_target_out;
    logic             valid_out;
    logic [WORD-1:0]  read_data_out;
    logic [WORD-1:0]  alu_result_out;
    logic [REG_W-1:0] write_register_out;
    logic             reg_write_out;
    logic             mem_to_reg_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .valid_in           (valid_in),
        .alu_result_in      (alu_result_in),
        .read_data2_in      (read_data2_in),
        .branch_target_in   (branch_target_in),
        .zero_in            (zero_in),
        .write_register_in  (write_register_in),
        .reg_write_in       (reg_write_in),
        .mem_to_reg_in      (mem_to_reg_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .branch_in          (branch_in),
        .uncond_branch_in   (uncond_branch_in),
        .bus                (bus),
        .stall              (stall),
        .pc_src             (pc_src),
        .branch_target_out  (branch_target_out),
        .valid_out          (valid_out),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .write_register_out (write_register_out),
        .reg_write_out      (reg_write_out),
        .mem_to_reg_out     (mem_to_reg_out)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ex(input logic v, input logic [63:0] alu, input logic [63:0] rd2,
                            input logic [63:0] tgt, input logic z, input logic [4:0] wr,
                            input logic rw, input logic m2r, input logic mr, input logic mw,
                            input logic br, input logic ub);
        valid_in          = v;
        alu_result_in     = alu;
        read_data2_in     = rd2;
        branch_target_in  = tgt;
        zero_in           = z;
        write_register_in = wr;
        reg_write_in      = rw;
        mem_to_reg_in     = m2r;
        mem_read_in       = mr;
        mem_write_in      = mw;
        branch_in         = br;
        uncond_branch_in  = ub;
    endtask

    task automatic clear_ex();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        clear_ex();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_req",       64'(bus.dmem_req), 64'd0);
        check("rst_stall",     64'(stall),        64'd0);
        check("rst_pc_src",    64'(pc_src),       64'd0);
        check("rst_valid_out", 64'(valid_out),    64'd0);
        check("rst_reg_write", 64'(reg_write_out), 64'd0);
        check("rst_read_data", read_data_out,     64'd0);
        check("rst_alu_out",   alu_result_out,    64'd0);
        check("rst_target",    branch_target_out, 64'd0);

        // Zero-wait load at 0x40 into x3
        drive_ex(1, 64'h40, 0, 0, 0, 5'd3, 1, 1, 1, 0, 0, 0);
        step();
        clear_ex();
        check("zw_req",       64'(bus.dmem_req),  64'd1);
        check("zw_addr",      bus.dmem_addr,      64'h40);
        check("zw_we",        64'(bus.dmem_we),   64'd0);
        check("zw_valid_n",   64'(valid_out),     64'd0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'hDEAD_BEEF;
        #1;
        check("zw_stall",     64'(stall),         64'd0);
        step();
        bus.dmem_ack = 1'b0;
        check("zw_valid_out", 64'(valid_out),     64'd1);
        check("zw_rdata",     read_data_out,      64'hDEAD_BEEF);
        check("zw_m2r",       64'(mem_to_reg_out), 64'd1);
        check("zw_rw",        64'(reg_write_out), 64'd1);
        check("zw_wreg",      64'(write_register_out), 64'd3);
        check("zw_req_done",  64'(bus.dmem_req),  64'd0);

        // Wait-state store: addr 0x80, data 0x1234, ack on the third cycle
        drive_ex(1, 64'h80, 64'h1234, 0, 0, 5'd9, 0, 0, 0, 1, 0, 0);
        step();
        drive_ex(0, 64'h999, 64'h999, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ws_req",       64'(bus.dmem_req),  64'd1);
        check("ws_we",        64'(bus.dmem_we),   64'd1);
        check("ws_addr",      bus.dmem_addr,      64'h80);
        check("ws_wdata",     bus.dmem_wdata,     64'h1234);
        check("ws_stall1",    64'(stall),         64'd1);
        step();
        check("ws_stall2",    64'(stall),         64'd1);
        check("ws_addr_hold", bus.dmem_addr,      64'h80);
        check("ws_wdata_hold", bus.dmem_wdata,    64'h1234);
        check("ws_we_hold",   64'(bus.dmem_we),   64'd1);
        check("ws_bubble",    64'(valid_out),     64'd0);
        step();
        check("ws_stall3",    64'(stall),         64'd1);
        check("ws_bubble2",   64'(valid_out),     64'd0);
        clear_ex();
        bus.dmem_ack = 1'b1;
        #1;
        check("ws_stall_ack", 64'(stall),         64'd0);
        step();
        bus.dmem_ack = 1'b0;
        check("ws_valid_out", 64'(valid_out),     64'd1);
        check("ws_rw",        64'(reg_write_out), 64'd0);
        check("ws_req_done",  64'(bus.dmem_req),  64'd0);

        // Back-to-back loads at 0x10 (x5) then 0x18 (x6), 2 cycles each
        drive_ex(1, 64'h10, 0, 0, 0, 5'd5, 1, 1, 1, 0, 0, 0);
        step();
        drive_ex(1, 64'h18, 0, 0, 0, 5'd6, 1, 1, 1, 0, 0, 0);
        check("bb_req1",      64'(bus.dmem_req),  64'd1);
        check("bb_addr1",     bus.dmem_addr,      64'h10);
        step();
        check("bb_addr1_hold", bus.dmem_addr,     64'h10);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'hAAAA;
        step();
        clear_ex();
        bus.dmem_ack = 1'b0;
        check("bb_req_cont",  64'(bus.dmem_req),  64'd1);
        check("bb_addr2",     bus.dmem_addr,      64'h18);
        check("bb_valid1",    64'(valid_out),     64'd1);
        check("bb_rdata1",    read_data_out,      64'hAAAA);
        check("bb_wreg1",     64'(write_register_out), 64'd5);
        step();
        check("bb_req_cont2", 64'(bus.dmem_req),  64'd1);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'hBBBB;
        step();
        bus.dmem_ack = 1'b0;
        check("bb_valid2",    64'(valid_out),     64'd1);
        check("bb_rdata2",    read_data_out,      64'hBBBB);
        check("bb_wreg2",     64'(write_register_out), 64'd6);
        check("bb_req_done",  64'(bus.dmem_req),  64'd0);

        // CBZ taken
        drive_ex(1, 0, 0, 64'h200, 1, 0, 0, 0, 0, 0, 1, 0);
        step();
        clear_ex();
        check("cbz_pc_src",   64'(pc_src),        64'd1);
        check("cbz_target",   branch_target_out,  64'h200);
        step();
        check("cbz_one_cycle", 64'(pc_src),       64'd0);
        check("cbz_wb_valid", 64'(valid_out),     64'd1);
        check("cbz_wb_rw",    64'(reg_write_out), 64'd0);

        // CBZ not taken
        drive_ex(1, 0, 0, 64'h200, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        clear_ex();
        check("cbz_nt_pc_src", 64'(pc_src),       64'd0);

        // Unconditional B with zero=0
        drive_ex(1, 0, 0, 64'h300, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        clear_ex();
        check("b_pc_src",     64'(pc_src),        64'd1);
        check("b_target",     branch_target_out,  64'h300);

        // Bubble carrying mem_read and reg_write, plus a stray ack in IDLE
        drive_ex(0, 64'h44, 0, 0, 1, 5'd2, 1, 1, 1, 0, 1, 1);
        bus.dmem_ack = 1'b1;
        step();
        clear_ex();
        check("bub_req",      64'(bus.dmem_req),  64'd0);
        check("bub_pc_src",   64'(pc_src),        64'd0);
        step();
        bus.dmem_ack = 1'b0;
        check("bub_req2",     64'(bus.dmem_req),  64'd0);
        check("bub_valid",    64'(valid_out),     64'd0);
        check("bub_rw",       64'(reg_write_out), 64'd0);
        #1;
        check("bub_stall",    64'(stall),         64'd0);

        // Load and store both set: the store wins, read data is 0
        drive_ex(1, 64'h90, 64'h77, 0, 0, 5'd4, 0, 0, 1, 1, 0, 0);
        step();
        clear_ex();
        check("ls_we",        64'(bus.dmem_we),   64'd1);
        check("ls_wdata",     bus.dmem_wdata,     64'h77);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'h5555;
        step();
        bus.dmem_ack = 1'b0;
        check("ls_valid",     64'(valid_out),     64'd1);
        check("ls_rdata",     read_data_out,      64'd0);

        // Reset during an access, ack arrives two cycles later
        drive_ex(1, 64'h60, 0, 0, 0, 5'd7, 1, 1, 1, 0, 0, 0);
        step();
        clear_ex();
        check("rma_req",      64'(bus.dmem_req),  64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rma_req_off",  64'(bus.dmem_req),  64'd0);
        check("rma_stall",    64'(stall),         64'd0);
        check("rma_addr",     bus.dmem_addr,      64'd0);
        check("rma_valid",    64'(valid_out),     64'd0);
        step();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'h1111;
        step();
        bus.dmem_ack = 1'b0;
        check("rma_late_req", 64'(bus.dmem_req),  64'd0);
        check("rma_late_valid", 64'(valid_out),   64'd0);
        check("rma_late_rdata", read_data_out,    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
